// File: rtl/sim_pkg.sv
// Shared definitions for the simulation halt monitor: halt reasons,
// control-state encoding and the BREAK instruction match pattern.
package sim_pkg;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'd0,
    HALT_BREAK   = 2'd1,
    HALT_STUCK   = 2'd2,
    HALT_TIMEOUT = 2'd3
  } halt_reason_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // BREAK encoding with its 15-bit code field zeroed, and the mask that
  // drops the code field before comparison.
  localparam logic [31:0] SIM_BREAK_OPCODE = 32'h002A0000;
  localparam logic [31:0] SIM_BREAK_MASK   = 32'hFFFF8000;

endpackage

// File: rtl/sim_halt_monitor_if.sv
// CPU commit (retire) stream: one retiring instruction per valid cycle.
interface sim_halt_monitor_if #(
  parameter int INST_WIDTH = 32
);
  logic                  commit_valid;
  logic [INST_WIDTH-1:0] commit_pc;
  logic [INST_WIDTH-1:0] commit_inst;

  modport master (output commit_valid, output commit_pc, output commit_inst);
  modport slave  (input  commit_valid, input  commit_pc, input  commit_inst);
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Priority: clear, then load, then increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_reg;

  // Count register: clear/load/saturating increment.
  always_ff @(posedge clk) begin
    if (clear) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_val;
    end else if (inc && !(&value_reg)) begin
      value_reg <= value_reg + WIDTH'(1);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/sim_halt_monitor.sv
// Watches the commit stream for a retired BREAK, a dead loop on one PC or a
// global cycle timeout; after a drain period raises is_break and holds it.
module sim_halt_monitor
  import sim_pkg::*;
#(
  parameter int                    INST_WIDTH     = 32,
  parameter int                    CNT_WIDTH      = 32,
  parameter logic [INST_WIDTH-1:0] BREAK_OPCODE   = INST_WIDTH'(SIM_BREAK_OPCODE),
  parameter logic [INST_WIDTH-1:0] BREAK_MASK     = INST_WIDTH'(SIM_BREAK_MASK),
  parameter int                    DRAIN_CYCLES   = 4,
  parameter int                    TIMEOUT_CYCLES = 1000000,
  parameter int                    STUCK_LIMIT    = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  sim_halt_monitor_if.slave     commit,
  output logic                  is_break,
  output logic [1:0]            halt_reason,
  output logic [INST_WIDTH-1:0] halt_pc,
  output logic [CNT_WIDTH-1:0]  retired_cnt,
  output logic [CNT_WIDTH-1:0]  cycle_cnt
);

  // Limits are compared in a width wider than the counters so that a limit
  // larger than a narrow counter can never match a truncated value.
  localparam int          WIDE      = CNT_WIDTH + 32;
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] STUCK_LIM = 32'(STUCK_LIMIT);
  localparam int          DRAIN_W   = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  state_t                state_reg, state_next;
  halt_reason_t          halt_reason_reg, halt_reason_next;
  logic [INST_WIDTH-1:0] halt_pc_reg, halt_pc_next;
  logic [INST_WIDTH-1:0] last_pc_reg;
  logic                  seen_reg;
  logic                  is_break_reg;
  logic [DRAIN_W-1:0]    drain_reg, drain_next;

  logic [CNT_WIDTH-1:0]  retired_value, cycle_value, stuck_value;
  logic [CNT_WIDTH:0]    stuck_would;
  logic                  run, commit_fire, same_pc;
  logic                  break_hit, stuck_hit, timeout_hit;

  // Halt condition detection in RUN, with the stuck counter's would-be value.
  always_comb begin
    run         = (state_reg == ST_RUN);
    commit_fire = run && commit.commit_valid;
    // Before the first commit last_pc is meaningless, so never treat it as a repeat.
    same_pc     = seen_reg && (commit.commit_pc == last_pc_reg);
    break_hit   = commit_fire && ((commit.commit_inst & BREAK_MASK) == BREAK_OPCODE);
    if (same_pc) begin
      stuck_would = {1'b0, stuck_value} + {{CNT_WIDTH{1'b0}}, ~(&stuck_value)};
    end else begin
      stuck_would = {{CNT_WIDTH{1'b0}}, 1'b1};
    end
    stuck_hit   = commit_fire && (WIDE'(stuck_would) == WIDE'(STUCK_LIM));
    timeout_hit = run && (WIDE'(cycle_value) == WIDE'(TO_LAST));
  end

  // Next-state and halt-field update logic.
  always_comb begin
    state_next       = state_reg;
    halt_reason_next = halt_reason_reg;
    halt_pc_next     = halt_pc_reg;
    drain_next       = drain_reg;
    case (state_reg)
      ST_RUN: begin
        if (break_hit || stuck_hit || timeout_hit) begin
          if (break_hit) begin
            halt_reason_next = HALT_BREAK;
            halt_pc_next     = commit.commit_pc;
          end else if (stuck_hit) begin
            halt_reason_next = HALT_STUCK;
            halt_pc_next     = commit.commit_pc;
          end else begin
            halt_reason_next = HALT_TIMEOUT;
            halt_pc_next     = last_pc_reg;
          end
          drain_next = DRAIN_W'(DRAIN_CYCLES);
          state_next = (DRAIN_CYCLES == 0) ? ST_HALT : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_next = drain_reg - DRAIN_W'(1);
        if (drain_reg == DRAIN_W'(1)) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State, halt fields, last committed PC and the registered break request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      halt_reason_reg <= HALT_NONE;
      halt_pc_reg     <= '0;
      last_pc_reg     <= '0;
      seen_reg        <= 1'b0;
      drain_reg       <= '0;
      is_break_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      halt_reason_reg <= halt_reason_next;
      halt_pc_reg     <= halt_pc_next;
      drain_reg       <= drain_next;
      is_break_reg    <= (state_reg == ST_HALT);
      if (commit_fire) begin
        last_pc_reg <= commit.commit_pc;
        seen_reg    <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_retired (
    .clk      (clk),
    .clear    (reset),
    .load     (1'b0),
    .inc      (commit_fire),
    .load_val ({CNT_WIDTH{1'b0}}),
    .value    (retired_value)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
    .clk      (clk),
    .clear    (reset),
    .load     (1'b0),
    .inc      (state_reg != ST_HALT),
    .load_val ({CNT_WIDTH{1'b0}}),
    .value    (cycle_value)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stuck (
    .clk      (clk),
    .clear    (reset),
    .load     (commit_fire && !same_pc),
    .inc      (commit_fire && same_pc),
    .load_val ({{(CNT_WIDTH-1){1'b0}}, 1'b1}),
    .value    (stuck_value)
  );

  assign is_break    = is_break_reg;
  assign halt_reason = halt_reason_reg;
  assign halt_pc     = halt_pc_reg;
  assign retired_cnt = retired_value;
  assign cycle_cnt   = cycle_value;

endmodule
